divider: RTL and testbench

Iterative 32-bit integer divider in the execute stage's multi-cycle unit, next to the multiplier and sharing its `valid`/`done` handshake. Produces quotient and remainder for DIV/DIVU as one 64-bit result: remainder in the upper half (HI), quotient in the lower half (LO). It uses one restoring shift-subtract datapath, iterated over many cycles, instead of a combinational array.

---
 rtl/divider_pkg.sv | 26 ++
 rtl/divider_if.sv | 22 ++
 rtl/div_step.sv | 31 +++
 rtl/divider.sv | 97 +++++++++
 tb/tb_divider.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared divider types and constants; DIVIDER_RADIX4_EN selects two steps per cycle
package divider_pkg;

    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    localparam int DIV_W = 32;

`ifdef DIVIDER_RADIX4_EN
    localparam int STEPS_PER_CYC = 2;
`else
    localparam int STEPS_PER_CYC = 1;
`endif

    localparam int DIV_CNT_W = 5;

    // Counter value of the final BUSY cycle.
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_CNT = DIV_CNT_W'(DIV_W / STEPS_PER_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// rtl/divider_if.sv - valid/done handshake bundle between requester and divider
interface divider_if;
    import divider_pkg::*;

    logic valid;
    logic is_signed;
    i32   a;
    i32   b;
    logic done;
    i64   c;

    modport master (
        output valid, is_signed, a, b,
        input  done, c
    );

    modport slave (
        input  valid, is_signed, a, b,
        output done, c
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step
    import divider_pkg::*;
(
    input  logic [DIV_W:0]   rem,
    input  logic [DIV_W-1:0] quot,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   rem_nxt,
    output logic [DIV_W-1:0] quot_nxt
);

    logic [DIV_W:0]   rem_sh;
    logic [DIV_W+1:0] trial;
    logic             unused_rem_msb;

    // rem stays below divisor, so its top bit is always clear going in.
    assign unused_rem_msb = rem[DIV_W];

    always_comb begin
        rem_sh = {rem[DIV_W-1:0], quot[DIV_W-1]};
        trial  = {1'b0, rem_sh} - {2'b00, divisor};
        if (trial[DIV_W+1]) begin
            rem_nxt  = rem_sh;
            quot_nxt = {quot[DIV_W-2:0], 1'b0};
        end else begin
            rem_nxt  = trial[DIV_W:0];
            quot_nxt = {quot[DIV_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative restoring DIV/DIVU unit; result {remainder, quotient}
module divider
    import divider_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);

    div_state_t             state;
    div_state_t             state_nxt;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [DIV_W:0]         rem;
    logic [DIV_W-1:0]       quot;
    logic [DIV_W-1:0]       divisor;
    logic                   q_neg;
    logic                   r_neg;
    logic                   b_zero;
    i64                     c_q;

    logic [STEPS_PER_CYC:0][DIV_W:0]   rem_s;
    logic [STEPS_PER_CYC:0][DIV_W-1:0] quot_s;
    logic [DIV_W-1:0]                  q_fin;
    logic [DIV_W-1:0]                  r_fin;

    assign rem_s[0]  = rem;
    assign quot_s[0] = quot;

    for (genvar i = 0; i < STEPS_PER_CYC; i++) begin : g_step
        div_step u_step (
            .rem      (rem_s[i]),
            .quot     (quot_s[i]),
            .divisor  (divisor),
            .rem_nxt  (rem_s[i+1]),
            .quot_nxt (quot_s[i+1])
        );
    end

    assign q_fin = quot_s[STEPS_PER_CYC];
    assign r_fin = rem_s[STEPS_PER_CYC][DIV_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.valid ? BUSY : IDLE;
            BUSY:    state_nxt = (cnt == DIV_LAST_CNT) ? FINISH : BUSY;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.done = (state_nxt == IDLE);
    assign bus.c    = c_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            b_zero  <= 1'b0;
            c_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        // Magnitude of 0x80000000 is itself when read as unsigned.
                        quot    <= (bus.is_signed && bus.a[DIV_W-1]) ? -bus.a : bus.a;
                        divisor <= (bus.is_signed && bus.b[DIV_W-1]) ? -bus.b : bus.b;
                        q_neg   <= bus.is_signed & (bus.a[DIV_W-1] ^ bus.b[DIV_W-1]);
                        r_neg   <= bus.is_signed & bus.a[DIV_W-1];
                        b_zero  <= (bus.b == '0);
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    rem  <= rem_s[STEPS_PER_CYC];
                    quot <= quot_s[STEPS_PER_CYC];
                    cnt  <= cnt + DIV_CNT_W'(1);
                    if (cnt == DIV_LAST_CNT) begin
                        // Divide by zero: the datapath already yields |a| as remainder,
                        // sign correction restores a; only the quotient is forced.
                        c_q[DIV_W-1:0]       <= b_zero ? '1 : (q_neg ? -q_fin : q_fin);
                        c_q[2*DIV_W-1:DIV_W] <= r_neg ? -r_fin : r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model
module tb_divider;
    import divider_pkg::*;

`ifdef DIVIDER_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;
    logic [63:0] prev_c;

    divider_if bus ();

    divider dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int cyc;
        bit held_bad;
        cyc = 0;
        held_bad = 0;
        @(posedge clk);
        #1;
        bus.valid     = 1'b1;
        bus.is_signed = sgn;
        bus.a         = a;
        bus.b         = b;
        @(negedge clk);
        check({tag, ":start_done"}, {63'd0, bus.done}, 64'd0);
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.a         = $urandom;
            bus.b         = $urandom;
            bus.is_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.done) break;
            if (bus.c !== prev_c) held_bad = 1;
        end
        check({tag, ":latency"}, 64'(cyc), 64'(LAT));
        check({tag, ":result"}, bus.c, exp);
        check({tag, ":held"}, {63'd0, held_bad}, 64'd0);
        prev_c = exp;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        n_tests       = 0;
        n_fail        = 0;
        prev_c        = 64'd0;
        resetn        = 1'b0;
        bus.valid     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_c", bus.c, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd1);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run_op("div_by0", 1'b1, 32'h1234_5678, 32'd0, 64'h12345678_FFFFFFFF);
        run_op("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 64'h12345678_FFFFFFFF);
        run_op("div_neg_by0", 1'b1, 32'h8765_4321, 32'd0, 64'h87654321_FFFFFFFF);

        // Abort an operation in BUSY cycle 10.
        @(posedge clk);
        #1;
        bus.valid     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd1000;
        bus.b         = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        resetn    = 1'b0;
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_c", bus.c, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd1);
        prev_c = 64'd0;
        run_op("rst_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
